alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one instance of the existing 32-bit combinational `ALU` between two requesters, e.g. the main datapath and a CSR/debug or multi-cycle helper unit.
- Arbitrates round-robin between the requesters and registers the operands.
- Runs the shared ALU for one cycle, registers the result, and returns it through a valid/ready response channel tagged with the requester id.
- Only one operation is in flight at a time.

Parameters:
- DATA_W, 32, operand/result width; fixed to 32 to match the ALU; any other value is unsupported.
- CNT_W, 16, width of the per-requester grant counters (optional feature only).

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid_i  input  1  requester 0 has an operation
- req0_ready_o  output  1  requester 0 accepted this cycle when high with valid
- req0_op_i  input  4  ALU operation code (ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0111, LUI 1001)
- req0_a_i  input  32  operand A
- req0_b_i  input  32  operand B
- req1_valid_i, req1_ready_o, req1_op_i, req1_a_i, req1_b_i  same as requester 0, for requester 1
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  consumer takes the response
- rsp_id_o  output  1  requester index of the response
- rsp_result_o  output  32  registered ALU result
- rsp_zero_o  output  1  registered ALU zero flag
- busy_o  output  1  high whenever state is not IDLE

Behaviour:
- States:
  - IDLE: accepts one request.
  - EXEC: ALU is driven from the operand registers.
  - RESP: result is held until the response is taken.
- Arbitration (combinational, IDLE only):
  - If exactly one valid is high, that requester is granted.
  - If both are high, the requester not equal to last_grant is granted.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Ready and acceptance:
  - reqN_ready_o = (state==IDLE) && granted==N.
  - At most one ready is high per cycle; ready never depends on any ready output.
  - Acceptance = valid && ready at a rising edge.
- Accept edge E0:
  - Register op, a, b and id into operand registers.
  - last_grant <= id; state <= EXEC.
- Edge E1 (in EXEC):
  - Register ALU_Result_o into rsp_result_o and Zero_o into rsp_zero_o; rsp_id_o <= id.
  - state <= RESP; rsp_valid_o rises.
  - Latency: response valid one cycle after the accept edge.
- RESP:
  - rsp_valid_o stays 1 and rsp_id_o, rsp_result_o, rsp_zero_o stay stable until rsp_valid_o && rsp_ready_i at an edge.
  - That edge returns the block to IDLE. The next acceptance is possible no earlier than the following edge.
  - Peak throughput: one operation per 3 cycles.
- Requests presented while not IDLE see ready=0 and are not latched; requesters must hold valid and payload until accepted.
- Undefined op codes are passed unchanged to the ALU: result 0, zero 1. No error is flagged.
- Shifts use the full 32-bit B value with no masking; B>=32 gives 0. This is the ALU's behaviour.
- Reset values:
  - state IDLE, last_grant 1.
  - rsp_valid_o 0, rsp_id_o 0, rsp_result_o 0, rsp_zero_o 0, busy_o 0.
  - Operand registers 0.
- Reset mid-operation (EXEC or RESP) abandons the operation; no response is ever produced for it.
- reset takes priority over every other event in the same cycle.

Optional Feature:
- Macro: ALU_SHARE_ARB_GRANT_CNT_EN.
- Defined:
  - Adds output ports grant_cnt0_o and grant_cnt1_o, each CNT_W bits.
  - Each counts accepted requests of its requester, increments at the accept edge, wraps from all-ones to 0, and resets to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU op-code localparams (ADD..LUI, 4-bit);
  - the state encoding (IDLE 2'd0, EXEC 2'd1, RESP 2'd2);
  - DATA_W.
- Sub-module: the existing `ALU`, instantiated once and unmodified.
- Arbitration is a small always block; a separate rr_arbiter sub-module is not warranted for 2 requesters.

Test Plan:
- Single requester: req0 ADD a=5 b=7 → accepted at E0; rsp_valid_o at E0+1 with id 0, result 12, zero 0.
- Tie: both valid after reset; req0 SUB 9-9, req1 OR 0xF0|0x0F, rsp_ready_i=1.
  - First response: id 0, result 0, zero 1.
  - Second response: id 1, result 0xFF.
  - Both held valid again: next grant goes to req0 (alternation).
- Backpressure: LUI b=0x12345, hold rsp_ready_i=0 for 4 cycles.
  - result 0x12345000 stays stable; both readies stay 0; busy_o stays 1.
  - Release: IDLE one cycle later.
- Shift boundaries:
  - SRL a=0x80000000 b=31 → 1.
  - SLL a=1 b=32 → 0, zero 1.
  - Undefined op 4'b1111 → 0, zero 1.
- Reset in EXEC and in RESP: assert reset for 1 cycle.
  - No response appears; all outputs return to reset values.
  - Next tie is granted to req0.
- With ALU_SHARE_ARB_GRANT_CNT_EN and CNT_W=2:
  - 5 req1 operations → grant_cnt1_o reads 1 (wrap); grant_cnt0_o stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, arbiter FSM state encoding and datapath width.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Existing 32-bit combinational ALU, shared by the arbiter.
module ALU
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] A_i,
  input  logic [DATA_W-1:0] B_i,
  input  logic [3:0]        ALUControl_i,
  output logic [DATA_W-1:0] ALU_Result_o,
  output logic              Zero_o
);

  always_comb begin
    ALU_Result_o = '0;
    case (ALUControl_i)
      ALU_ADD: ALU_Result_o = A_i + B_i;
      ALU_SUB: ALU_Result_o = A_i - B_i;
      ALU_XOR: ALU_Result_o = A_i ^ B_i;
      ALU_OR:  ALU_Result_o = A_i | B_i;
      ALU_AND: ALU_Result_o = A_i & B_i;
      // Full-width shift amount: anything of 32 or more shifts everything out.
      ALU_SLL: ALU_Result_o = A_i << B_i;
      ALU_SRL: ALU_Result_o = A_i >> B_i;
      ALU_LUI: ALU_Result_o = {B_i[19:0], 12'd0};
      default: ALU_Result_o = '0;
    endcase
  end

  assign Zero_o = (ALU_Result_o == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters, one op in flight.
// Optional per-requester grant counters when ALU_SHARE_ARB_GRANT_CNT_EN is defined.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [3:0]        req0_op_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [3:0]        req1_op_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic              busy_o
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
  , output logic [CNT_W-1:0] grant_cnt0_o
  , output logic [CNT_W-1:0] grant_cnt1_o
`endif
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              rsp_id_q, rsp_id_d;

  logic              gnt_valid;
  logic              gnt_id;
  logic              accept;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt_valid = req0_valid_i | req1_valid_i;
    gnt_id    = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      gnt_id = ~last_grant_q;
    end else if (req1_valid_i) begin
      gnt_id = 1'b1;
    end
  end

  assign accept       = (state_q == IDLE) && gnt_valid;
  assign req0_ready_o = accept && !gnt_id;
  assign req1_ready_o = accept && gnt_id;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    result_d     = result_q;
    zero_d       = zero_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d         = gnt_id ? req1_op_i : req0_op_i;
          a_d          = gnt_id ? req1_a_i  : req0_a_i;
          b_d          = gnt_id ? req1_b_i  : req0_b_i;
          id_d         = gnt_id;
          last_grant_d = gnt_id;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        rsp_id_d = id_q;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  ALU u_alu (
    .A_i          (a_q),
    .B_i          (b_q),
    .ALUControl_i (op_q),
    .ALU_Result_o (alu_result),
    .Zero_o       (alu_zero)
  );

  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = result_q;
  assign rsp_zero_o   = zero_q;
  assign busy_o       = (state_q != IDLE);

`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (accept) begin
      if (gnt_id) begin
        cnt1_q <= cnt1_q + CNT_W'(1);
      end else begin
        cnt0_q <= cnt0_q + CNT_W'(1);
      end
    end
  end

  assign grant_cnt0_o = cnt0_q;
  assign grant_cnt1_o = cnt1_q;
`endif

endmodule
